// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, ALU operand-B source encodings, word type.
package mips_pkg;
  localparam int   WORD_W     = 32;
  localparam logic ALUSRC_REG = 1'b0;
  localparam logic ALUSRC_IMM = 1'b1;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mux_after_register_file_mux2.sv
// Generic 2:1 combinational select. Only a clean 1 on sel_i picks b_i; X/Z fall to a_i.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  always_comb begin
    y_o = a_i;
    if (sel_i) y_o = b_i;
  end
endmodule

// File: rtl/mux_after_register_file.sv
// ALU operand-B selector (ReadData2 vs sign-extended immediate) with an ID/EX-style holding register.
// Optional immediate-use counter enabled by macro MUXARF_IMMCOUNT_EN.
module mux_after_register_file
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] Extend16to32,
  output logic [WIDTH-1:0] Result,
  input  logic             En,
  input  logic             Flush,
  output logic [WIDTH-1:0] ResultQ,
  output logic             SrcQ,
  output logic             ValidQ,
  output logic [CNT_W-1:0] ImmCount
);
  logic [WIDTH-1:0] res_d, res_q;
  logic             src_d, src_q;
  logic             vld_d, vld_q;

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (ALUSrc),
    .a_i   (ReadData2),
    .b_i   (Extend16to32),
    .y_o   (Result)
  );

  // Flush beats enable; with neither, the stage stalls.
  always_comb begin
    res_d = res_q;
    src_d = src_q;
    vld_d = vld_q;
    if (Flush) begin
      res_d = '0;
      src_d = ALUSRC_REG;
      vld_d = 1'b0;
    end else if (En) begin
      res_d = Result;
      src_d = (ALUSrc == ALUSRC_IMM);
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      src_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      src_q <= src_d;
      vld_q <= vld_d;
    end
  end

  assign ResultQ = res_q;
  assign SrcQ    = src_q;
  assign ValidQ  = vld_q;

`ifdef MUXARF_IMMCOUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Saturating; a flush does not clear it.
  always_comb begin
    cnt_d = cnt_q;
    if (En && !Flush && (ALUSrc == ALUSRC_IMM) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ImmCount = cnt_q;
`else
  assign ImmCount = '0;
`endif
endmodule

// File: tb/tb_mux_after_register_file.sv
// Scoreboard bench for mux_after_register_file (CNT_W=2); honours MUXARF_IMMCOUNT_EN.
module tb_mux_after_register_file;
  localparam int W = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ALUSrc = 1'b0;
  logic [W-1:0]  ReadData2 = '0;
  logic [W-1:0]  Extend16to32 = '0;
  logic          En = 1'b0;
  logic          Flush = 1'b0;
  logic [W-1:0]  Result, ResultQ;
  logic          SrcQ, ValidQ;
  logic [CW-1:0] ImmCount;

  typedef struct {
    logic [W-1:0]  res;
    logic          src;
    logic          vld;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0]  m_res = '0;
  logic          m_src = 1'b0;
  logic          m_vld = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  int n_chk = 0;
  int n_fail = 0;

  mux_after_register_file #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ALUSrc(ALUSrc), .ReadData2(ReadData2),
    .Extend16to32(Extend16to32), .Result(Result), .En(En), .Flush(Flush),
    .ResultQ(ResultQ), .SrcQ(SrcQ), .ValidQ(ValidQ), .ImmCount(ImmCount)
  );

  always #5 clk = ~clk;

  // Drive at negedge, check Result, push model state, check registered outputs 1 ns after edge.
  task automatic step(input string nm, input logic en, input logic fl, input logic src,
                      input logic [W-1:0] rd2, input logic [W-1:0] ext);
    exp_t e;
    logic [W-1:0] sel;
    @(negedge clk);
    En = en; Flush = fl; ALUSrc = src; ReadData2 = rd2; Extend16to32 = ext;
    sel = src ? ext : rd2;
    #1;
    n_chk++;
    if (Result !== sel) begin
      n_fail++;
      $display("FAIL %s Result got %h expected %h", nm, Result, sel);
    end
    if (fl) begin
      m_res = '0; m_src = 1'b0; m_vld = 1'b0;
    end else if (en) begin
      m_res = sel; m_src = src; m_vld = 1'b1;
`ifdef MUXARF_IMMCOUNT_EN
      if (src && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`endif
    end
    e.res = m_res; e.src = m_src; e.vld = m_vld; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_chk++;
    if (ResultQ !== e.res || SrcQ !== e.src || ValidQ !== e.vld || ImmCount !== e.cnt) begin
      n_fail++;
      $display("FAIL %s regs got Q=%h S=%b V=%b C=%0d expected Q=%h S=%b V=%b C=%0d",
               nm, ResultQ, SrcQ, ValidQ, ImmCount, e.res, e.src, e.vld, e.cnt);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ResultQ !== '0 || SrcQ !== 1'b0 || ValidQ !== 1'b0 || ImmCount !== '0) begin
      n_fail++;
      $display("FAIL reset_state got Q=%h S=%b V=%b C=%0d expected all 0",
               ResultQ, SrcQ, ValidQ, ImmCount);
    end
  endtask

  task automatic test_comb();
    ALUSrc = 1'b1; ReadData2 = 32'h0001_0000; Extend16to32 = 32'h0000_0110;
    #20;
    n_chk++;
    if (Result !== 32'h0000_0110) begin
      n_fail++; $display("FAIL comb_imm got %h expected %h", Result, 32'h0000_0110);
    end
    ALUSrc = 1'b0; #1;
    n_chk++;
    if (Result !== 32'h0001_0000) begin
      n_fail++; $display("FAIL comb_reg got %h expected %h", Result, 32'h0001_0000);
    end
    ALUSrc = 1'bx; #1;
    n_chk++;
    if (Result !== 32'h0001_0000) begin
      n_fail++; $display("FAIL comb_x got %h expected %h", Result, 32'h0001_0000);
    end
    ALUSrc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    step("capture_imm", 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FF80);
    step("capture_reg", 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0000_7FFF);
  endtask

  task automatic test_stall_flush();
    step("pre_stall", 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FF80);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
    step("flush_en", 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    step("after_flush", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_async_reset();
    step("pre_rst", 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h8000_0001);
    #2 rst_n = 1'b0;
    #1;
    m_res = '0; m_src = 1'b0; m_vld = 1'b0; m_cnt = '0;
    n_chk++;
    if (ResultQ !== '0 || SrcQ !== 1'b0 || ValidQ !== 1'b0 || ImmCount !== '0) begin
      n_fail++;
      $display("FAIL async_rst regs got Q=%h S=%b V=%b C=%0d expected all 0",
               ResultQ, SrcQ, ValidQ, ImmCount);
    end
    n_chk++;
    if (Result !== 32'h8000_0001) begin
      n_fail++; $display("FAIL async_rst_comb got %h expected %h", Result, 32'h8000_0001);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_immcount();
    for (int i = 0; i < 5; i++)
      step("imm_cnt", 1'b1, 1'b0, 1'b1, 32'h0, 32'(i));
    step("reg_cnt", 1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
    step("flush_cnt", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    n_chk++;
`ifdef MUXARF_IMMCOUNT_EN
    if (ImmCount !== 2'd3) begin
      n_fail++; $display("FAIL immcount_sat got %0d expected 3", ImmCount);
    end
`else
    if (ImmCount !== 2'd0) begin
      n_fail++; $display("FAIL immcount_off got %0d expected 0", ImmCount);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++)
      step("b2b", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom), $urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_comb();
    test_capture();
    test_stall_flush();
    test_async_reset();
    test_immcount();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
